// File: rtl/compressor_pkg.sv
// Shared constants and row type for the 3:2 compressor array.
// COMP_PIPE_LATENCY follows the COMPRESSOR_3_2_PIPE_EN build macro.
package compressor_pkg;

   localparam int unsigned COMP_WIDTH_DEFAULT = 32;

`ifdef COMPRESSOR_3_2_PIPE_EN
   localparam int unsigned COMP_PIPE_LATENCY = 1;
`else
   localparam int unsigned COMP_PIPE_LATENCY = 0;
`endif

   typedef logic [COMP_WIDTH_DEFAULT-1:0] comp_row_t;

endpackage

// File: rtl/compressor_3_2_array_fa_cell.sv
// Single-bit full adder: one column of the 3:2 compressor.
module fa_cell
   import compressor_pkg::*;
(
   input  logic i0,
   input  logic i1,
   input  logic ci,
   output logic d,
   output logic co
);

   assign d  = i0 ^ i1 ^ ci;
   assign co = (i0 & i1) | (i0 & ci) | (i1 & ci);

endmodule

// File: rtl/compressor_3_2_array.sv
// WIDTH-column 3:2 carry-save compressor; co[k] carries weight 2^(k+1).
// Build macro COMPRESSOR_3_2_PIPE_EN adds one output register stage.
module compressor_3_2_array
   import compressor_pkg::*;
#(
   parameter int unsigned WIDTH = COMP_WIDTH_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] ci,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] co,
   output logic             valid_out
);

   logic [WIDTH-1:0] d_comb;
   logic [WIDTH-1:0] co_comb;

   for (genvar k = 0; k < WIDTH; k++) begin : g_col
      fa_cell u_fa (
         .i0 (i0[k]),
         .i1 (i1[k]),
         .ci (ci[k]),
         .d  (d_comb[k]),
         .co (co_comb[k])
      );
   end

`ifdef COMPRESSOR_3_2_PIPE_EN
   // Data is captured every cycle; valid only qualifies it.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         d         <= '0;
         co        <= '0;
         valid_out <= 1'b0;
      end else begin
         d         <= d_comb;
         co        <= co_comb;
         valid_out <= valid_in;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = sys_clk ^ sys_rst_n;

   assign d         = d_comb;
   assign co        = co_comb;
   assign valid_out = valid_in;
`endif

endmodule

// File: tb/tb_compressor_3_2_array.sv
// Scoreboard bench for compressor_3_2_array (WIDTH=32 and WIDTH=1 instances).
// Works in both COMPRESSOR_3_2_PIPE_EN builds; expected latency from the package.
module tb_compressor_3_2_array;
   import compressor_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] co;
      int          cyc;
   } exp_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;

   logic        valid_in = 1'b0;
   logic [31:0] i0 = '0, i1 = '0, ci = '0;
   logic [31:0] d, co;
   logic        valid_out;

   logic        w1_valid_in = 1'b0;
   logic [0:0]  w1_i0 = '0, w1_i1 = '0, w1_ci = '0;
   logic [0:0]  w1_d, w1_co;
   logic        w1_valid_out;

   exp_t        q[$];
   exp_t        q1[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic        mon_en = 1'b1;

   compressor_3_2_array #(.WIDTH(32)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .valid_in  (valid_in),
      .i0        (i0),
      .i1        (i1),
      .ci        (ci),
      .d         (d),
      .co        (co),
      .valid_out (valid_out)
   );

   compressor_3_2_array #(.WIDTH(1)) dut1 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .valid_in  (w1_valid_in),
      .i0        (w1_i0),
      .i1        (w1_i1),
      .ci        (w1_ci),
      .d         (w1_d),
      .co        (w1_co),
      .valid_out (w1_valid_out)
   );

   always #10 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc++;

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the 32-bit instance: pops one entry per valid output.
   always @(negedge sys_clk) begin
      if (mon_en && valid_out === 1'b1) begin
         if (q.size() == 0) begin
            chk("w32_unexpected_valid", 34'(valid_out), 34'd0);
         end else begin
            exp_t e;
            logic [33:0] lhs, rhs;
            e = q.pop_front();
            lhs = {2'b0, e.a} + {2'b0, e.b} + {2'b0, e.c};
            rhs = {2'b0, d} + {1'b0, co, 1'b0};
            chk("w32_d", 34'(d), 34'(e.d));
            chk("w32_co", 34'(co), 34'(e.co));
            chk("w32_latency", 34'(cyc), 34'(e.cyc + int'(COMP_PIPE_LATENCY)));
            chk("w32_invariant", rhs, lhs);
         end
      end
   end

   always @(negedge sys_clk) begin
      if (mon_en && w1_valid_out === 1'b1) begin
         if (q1.size() == 0) begin
            chk("w1_unexpected_valid", 34'(w1_valid_out), 34'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("w1_d", 34'(w1_d), 34'(e.d));
            chk("w1_co", 34'(w1_co), 34'(e.co));
            chk("w1_latency", 34'(cyc), 34'(e.cyc + int'(COMP_PIPE_LATENCY)));
         end
      end
   end

   task automatic send(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] ed, input logic [31:0] eco);
      exp_t e;
      @(posedge sys_clk);
      #1;
      valid_in = v;
      i0 = a;
      i1 = b;
      ci = c;
      if (v) begin
         e.a = a; e.b = b; e.c = c; e.d = ed; e.co = eco; e.cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge sys_clk);
      #1;
      valid_in = 1'b0;
      i0 = '0;
      i1 = '0;
      ci = '0;
      w1_valid_in = 1'b0;
   endtask

   task automatic send1(input logic a, input logic b, input logic c,
                        input logic ed, input logic eco);
      exp_t e;
      @(posedge sys_clk);
      #1;
      w1_valid_in = 1'b1;
      w1_i0 = a;
      w1_i1 = b;
      w1_ci = c;
      e.a = 32'(a); e.b = 32'(b); e.c = 32'(c);
      e.d = 32'(ed); e.co = 32'(eco); e.cyc = cyc;
      q1.push_back(e);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] tt_d;
      logic [1:0] tt_co;
      logic [31:0] a, b, c;

      // Reset state with idle inputs: all outputs zero in either build.
      #5;
      chk("rst_d", 34'(d), 34'd0);
      chk("rst_co", 34'(co), 34'd0);
      chk("rst_valid", 34'(valid_out), 34'd0);
      chk("rst_w1_valid", 34'(w1_valid_out), 34'd0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #5 sys_rst_n = 1'b1;

      // WIDTH=1 truth table: ci=0 then ci=1, {i1,i0} = 00,01,10,11.
      send1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      send1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      send1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      send1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      send1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();

      // Directed 32-bit vectors with hand-computed results.
      send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFE, 32'h8000_0001);
      send(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      send(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
      send(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'h0, 32'h0);
      idle();
      // Single-cycle pulse; the following cycle must not show valid_out.
      send(1'b1, 32'h5, 32'h3, 32'h6, 32'h0, 32'h7);
      idle();
      idle();

`ifdef COMPRESSOR_3_2_PIPE_EN
      // Mid-stream reset: in-flight sample dropped asynchronously.
      mon_en = 1'b0;
      @(posedge sys_clk);
      #1;
      valid_in = 1'b1; i0 = 32'h5; i1 = 32'h3; ci = 32'h6;
      @(posedge sys_clk);
      #1;
      valid_in = 1'b0; i0 = '0; i1 = '0; ci = '0;
      chk("pre_rst_valid", 34'(valid_out), 34'd1);
      chk("pre_rst_co", 34'(co), 34'h7);
      #4 sys_rst_n = 1'b0;
      #1;
      chk("async_rst_d", 34'(d), 34'd0);
      chk("async_rst_co", 34'(co), 34'd0);
      chk("async_rst_valid", 34'(valid_out), 34'd0);
      @(posedge sys_clk);
      #1;
      valid_in = 1'b1; i0 = 32'hFFFF_FFFF; i1 = 32'hFFFF_FFFF; ci = 32'hFFFF_FFFF;
      @(posedge sys_clk);
      #1;
      chk("held_rst_co", 34'(co), 34'd0);
      chk("held_rst_valid", 34'(valid_out), 34'd0);
      valid_in = 1'b0; i0 = '0; i1 = '0; ci = '0;
      #4 sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("post_rst_d", 34'(d), 34'd0);
      chk("post_rst_co", 34'(co), 34'd0);
      chk("post_rst_valid", 34'(valid_out), 34'd0);
      mon_en = 1'b1;
`else
      // Reset has no effect on the combinational build.
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b0;
      send(1'b1, 32'h5, 32'h3, 32'h6, 32'h0, 32'h7);
      idle();
      #4 sys_rst_n = 1'b1;
`endif
      send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFE, 32'h8000_0001);
      idle();

      // Random regression with sporadic idle cycles.
      for (int n = 0; n < 10000; n++) begin
         a = $urandom;
         b = $urandom;
         c = $urandom;
         tt_d = 2'($urandom_range(0, 3));
         send(tt_d != 2'd0, a, b, c, a ^ b ^ c, (a & b) | (a & c) | (b & c));
      end
      idle();
      idle();
      idle();

      tt_co = 2'(q.size() > 3 ? 3 : q.size());
      chk("w32_drain", 34'(tt_co), 34'd0);
      chk("w1_drain", 34'(q1.size()), 34'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
